// File: rtl/instruction_memory_controller_pkg.sv
// instruction_memory_controller_pkg: shared instruction/address types and the per-channel controller state.
package instruction_memory_controller_pkg;
    localparam int INSTRUCTION_WIDTH         = 32;
    localparam int INSTRUCTION_ADDRESS_WIDTH = 16;
    typedef logic [INSTRUCTION_WIDTH-1:0]         instruction_t;
    typedef logic [INSTRUCTION_ADDRESS_WIDTH-1:0] instruction_memory_address_t;
    typedef enum logic [1:0] {IDLE, READ_WAITING, RELAYING} controller_state_t;
endpackage

// File: rtl/instruction_memory_controller.sv
// instruction_memory_controller: round-robin fetch arbiter between warp fetchers and memory read channels.
// Ports:
//   clk, reset (async, active-low)
//   consumer_read_valid/address  in  per-warp fetch requests
//   consumer_read_ready/data     out one-cycle completion pulse with instruction
//   mem_read_valid/address       out per-channel memory request (registered)
//   mem_read_ready/data          in  per-channel memory completion
module instruction_memory_controller
    import instruction_memory_controller_pkg::*;
#(
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CONSUMERS-1:0]    consumer_read_valid,
    input  instruction_memory_address_t consumer_read_address [NUM_CONSUMERS],
    output logic [NUM_CONSUMERS-1:0]    consumer_read_ready,
    output instruction_t                consumer_read_data [NUM_CONSUMERS],
    output logic [NUM_CHANNELS-1:0]     mem_read_valid,
    output instruction_memory_address_t mem_read_address [NUM_CHANNELS],
    input  logic [NUM_CHANNELS-1:0]     mem_read_ready,
    input  instruction_t                mem_read_data [NUM_CHANNELS]
);
    localparam int PW = NUM_CONSUMERS > 1 ? $clog2(NUM_CONSUMERS) : 1;

    controller_state_t           r_state [NUM_CHANNELS];
    logic [NUM_CONSUMERS-1:0]    r_owner [NUM_CHANNELS];
    instruction_t                r_data [NUM_CHANNELS];
    instruction_memory_address_t r_addr [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]     r_mem_valid;
    logic [NUM_CHANNELS-1:0]     r_pulse;
    logic [PW-1:0]               r_ptr;

    logic [NUM_CONSUMERS-1:0]    w_busy;
    logic [NUM_CONSUMERS-1:0]    w_grant [NUM_CHANNELS];
    instruction_memory_address_t w_grant_addr [NUM_CHANNELS];
    logic [PW-1:0]               w_idx;
    logic [PW-1:0]               w_next_ptr;

    // Consumers owned by a non-idle channel are busy; each idle channel then
    // adds its own grant so higher channels never pick the same consumer.
    always_comb begin
        w_busy     = '0;
        w_next_ptr = r_ptr;
        w_idx      = '0;
        for (int c = 0; c < NUM_CHANNELS; c++)
            if (r_state[c] != IDLE) w_busy = w_busy | r_owner[c];
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            w_grant[c]      = '0;
            w_grant_addr[c] = '0;
            if (r_state[c] == IDLE) begin
                // Scan from the far end so the candidate nearest the pointer is written last and wins.
                for (int k = NUM_CONSUMERS - 1; k >= 0; k--) begin
                    w_idx = PW'((int'(r_ptr) + k) % NUM_CONSUMERS);
                    if (consumer_read_valid[w_idx] && !w_busy[w_idx]) begin
                        w_grant[c]        = '0;
                        w_grant[c][w_idx] = 1'b1;
                        w_grant_addr[c]   = consumer_read_address[w_idx];
                        w_next_ptr        = PW'((int'(w_idx) + 1) % NUM_CONSUMERS);
                    end
                end
            end
            w_busy = w_busy | w_grant[c];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr       <= '0;
            r_mem_valid <= '0;
            r_pulse     <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                r_state[c] <= IDLE;
                r_owner[c] <= '0;
                r_data[c]  <= '0;
                r_addr[c]  <= '0;
            end
        end else begin
            r_ptr <= w_next_ptr;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                r_pulse[c] <= 1'b0;
                case (r_state[c])
                    IDLE: if (|w_grant[c]) begin
                        r_mem_valid[c] <= 1'b1;
                        r_addr[c]      <= w_grant_addr[c];
                        r_owner[c]     <= w_grant[c];
                        r_state[c]     <= READ_WAITING;
                    end
                    READ_WAITING: if (mem_read_ready[c]) begin
                        r_data[c]      <= mem_read_data[c];
                        r_mem_valid[c] <= 1'b0;
                        r_pulse[c]     <= 1'b1;
                        r_state[c]     <= RELAYING;
                    end
                    // Hold ownership until the consumer lowers valid so a held request is served once.
                    RELAYING: if (!(|(consumer_read_valid & r_owner[c]))) r_state[c] <= IDLE;
                    default: r_state[c] <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        consumer_read_ready = '0;
        for (int i = 0; i < NUM_CONSUMERS; i++) consumer_read_data[i] = '0;
        for (int c = 0; c < NUM_CHANNELS; c++)
            for (int i = 0; i < NUM_CONSUMERS; i++)
                if (r_pulse[c] && r_owner[c][i]) begin
                    consumer_read_ready[i] = 1'b1;
                    consumer_read_data[i]  = r_data[c];
                end
    end

    assign mem_read_valid   = r_mem_valid;
    assign mem_read_address = r_addr;
endmodule

// File: doc/instruction_memory_controller.md
INSTRUCTION_MEMORY_CONTROLLER -- requirements
Module: instruction_memory_controller

Interface
REQ-001 SHALL have parameter NUM_CONSUMERS, default 4, number of requesting warp fetchers (equals WARPS_PER_CORE).
REQ-002 SHALL have parameter NUM_CHANNELS, default 1, number of memory read channels; legal range 1..NUM_CONSUMERS.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port consumer_read_valid, input, NUM_CONSUMERS bits: per-warp fetch request.
REQ-006 SHALL have port consumer_read_address, input, instruction_memory_address_t [NUM_CONSUMERS]: per-warp fetch address.
REQ-007 SHALL have port consumer_read_ready, output, NUM_CONSUMERS bits: per-warp one-cycle completion pulse.
REQ-008 SHALL have port consumer_read_data, output, instruction_t [NUM_CONSUMERS]: returned instruction, valid while ready is high.
REQ-009 SHALL have port mem_read_valid, output, NUM_CHANNELS bits: per-channel memory request.
REQ-010 SHALL have port mem_read_address, output, instruction_memory_address_t [NUM_CHANNELS]: per-channel memory address.
REQ-011 SHALL have port mem_read_ready, input, NUM_CHANNELS bits: per-channel memory completion.
REQ-012 SHALL have port mem_read_data, input, instruction_t [NUM_CHANNELS]: per-channel memory data, sampled when ready is high.

Function
REQ-013 SHALL run one FSM per channel with states IDLE, READ_WAITING, RELAYING.
REQ-014 SHALL, in IDLE, grant the first requesting consumer at or after the round-robin pointer that no other channel holds, or is granting this cycle.
REQ-015 SHALL resolve simultaneous grants from several idle channels in ascending channel order, with no consumer granted twice.
REQ-016 SHALL, on a grant, register mem_read_valid=1 and the consumer address (visible next cycle), record the owner, enter READ_WAITING, and move the pointer to owner+1 modulo NUM_CONSUMERS.
REQ-017 SHALL hold mem_read_valid and mem_read_address stable in READ_WAITING until mem_read_ready=1.
REQ-018 SHALL, on mem_read_ready=1, at that edge latch mem_read_data, drop mem_read_valid and enter RELAYING.
REQ-019 SHALL drive consumer_read_ready[owner]=1 with the latched data for exactly the first RELAYING cycle.
REQ-020 SHALL leave RELAYING for IDLE only when consumer_read_valid[owner]=0, so that a held valid is never served twice.
REQ-021 SHALL give a minimum request-to-ready latency of 2 cycles: valid in cycle 0, mem_read_valid in cycle 1, and, if mem_read_ready=1 in cycle 1, consumer_read_ready in cycle 2.
REQ-022 SHALL still complete and pulse ready if a consumer drops valid mid-request (protocol violation); that consumer's address change after grant SHALL be ignored.
REQ-023 SHALL drive consumer_read_data to 0 and consumer_read_ready to 0 for non-owned consumers.
REQ-024 SHALL keep the pointer unchanged when no grant occurs.

Reset
REQ-025 SHALL, while reset=0, asynchronously force all FSMs to IDLE and clear all of the following to 0: mem_read_valid, mem_read_address, consumer_read_ready, consumer_read_data, owners, latched data and the pointer.
REQ-026 SHALL, on reset during READ_WAITING, abandon the in-flight read; a late mem_read_ready SHALL then be ignored while the channel is IDLE.

Structure
REQ-027 SHALL take instruction_t and instruction_memory_address_t from the shared package, and SHALL add controller_state_t (IDLE, READ_WAITING, RELAYING) to that package.
REQ-028 SHALL, if split at all, use one sub-module, rr_arbiter (request vector, busy mask, pointer -> one-hot grant).

Verification
REQ-029 SHALL be verified with single request, 1 channel: warp 2 requests addr 0x10; memory returns ready in the same cycle with data 0xDEADBEEF -> consumer_read_ready[2] pulses 1 cycle in cycle 2 with data 0xDEADBEEF.
REQ-030 SHALL be verified with held valid: warp 0 holds valid for 5 cycles after ready -> exactly one mem_read_valid transaction.
REQ-031 SHALL be verified with contention, 1 channel: warps 0-3 request together -> service order 0,1,2,3; then warps 0 and 3 re-request -> order 0,3.
REQ-032 SHALL be verified with 2 channels: warps 1 and 3 request together -> channel 0 serves 1 and channel 1 serves 3 in the same cycle, with no duplication.
REQ-033 SHALL be verified with memory stall: mem_read_ready held 0 for 10 cycles -> mem_read_address stays constant and no consumer ready is seen.
REQ-034 SHALL be verified with reset mid-read: reset=0 in READ_WAITING -> all outputs 0 immediately; a late mem_read_ready produces no consumer ready.
